cp0_exc_unit: RTL and testbench

- Parametrised CP0 and exception/interrupt controller for the writeback stage of the five-stage MIPS pipeline.
- Owns Status, Cause, EPC, BadVAddr, Count and Compare.
- Prioritises exceptions, interrupts and eret, then issues a one-cycle redirect/cancel to fetch.
- Generalises the earlier writeback CP0 logic: configurable hardware interrupt lines, configurable timer divider, synchronised external interrupts, and a post-redirect flush state.

---
 rtl/cp0_pkg.sv | 44 ++++
 rtl/cp0_timer.sv | 55 +++++
 rtl/cp0_exc_unit.sv | 200 ++++++++++++++++++++
 tb/tb_cp0_exc_unit.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register addresses, exception codes, field positions and write masks
package cp0_pkg;

    // CP0 register addresses as {rd, sel}
    localparam logic [7:0] CP0_ADDR_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] CP0_ADDR_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] CP0_ADDR_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] CP0_ADDR_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] CP0_ADDR_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] CP0_ADDR_EPC      = {5'd14, 3'd0};

    // Cause.ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Status fields
    localparam int ST_IE  = 0;
    localparam int ST_EXL = 1;
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    // Cause fields
    localparam int CA_SW_LO = 8;

    // wb_exc bit indices
    localparam int WB_EXC_FETCH   = 6;
    localparam int WB_EXC_RSVD    = 5;
    localparam int WB_EXC_OVF     = 4;
    localparam int WB_EXC_SYSCALL = 3;
    localparam int WB_EXC_BRK     = 2;
    localparam int WB_EXC_RADDR   = 1;
    localparam int WB_EXC_WADDR   = 0;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } cp0_state_t;

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare timer with clock divider and edge-detected TI
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int DW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(COUNT_DIV - 1);

    logic [DW-1:0] div;
    logic          tick;
    logic [31:0]   count_inc;

    assign tick      = (div == DIV_LAST);
    assign count_inc = count + 32'd1;

    // Divider runs 0..COUNT_DIV-1 and wraps on tick
    always_ff @(posedge clk) begin
        if (!resetn) begin
            div <= '0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
        end
    end

    // Count/Compare registers; software writes beat the increment and the match
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            if (count_we) begin
                count <= wdata;
            end else if (tick) begin
                count <= count_inc;
            end
            if (compare_we) begin
                compare <= wdata;
                ti      <= 1'b0;
            end else if (tick && !count_we && (count_inc == compare)) begin
                ti <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_exc_unit.sv
// rtl/cp0_exc_unit.sv - writeback CP0 and exception/interrupt controller; timer under CP0_TIMER_EN
module cp0_exc_unit
    import cp0_pkg::*;
#(
    parameter int          NUM_HW_INT = 6,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wb_valid,
    input  logic [31:0]           wb_pc,
    input  logic                  wb_delay_slot,
    input  logic [6:0]            wb_exc,
    input  logic [31:0]           wb_dm_addr,
    input  logic                  wb_eret,
    input  logic                  wb_mtc0,
    input  logic [7:0]            cp0_addr,
    input  logic [31:0]           cp0_wdata,
    output logic [31:0]           cp0_rdata,
    input  logic [NUM_HW_INT-1:0] hw_int,
    output logic                  wb_commit,
    output logic                  exc_valid,
    output logic [31:0]           exc_pc,
    output logic                  cancel,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o
);

    if (NUM_HW_INT < 1 || NUM_HW_INT > 6 || COUNT_DIV < 1) begin : g_bad_params
        $error("cp0_exc_unit: NUM_HW_INT must be 1..6 and COUNT_DIV >= 1");
    end

    cp0_state_t state, state_next;

    logic [31:0]           status, epc, badvaddr, cause;
    logic                  cause_bd;
    logic [4:0]            cause_exc;
    logic [1:0]            cause_sw;
    logic [NUM_HW_INT-1:0] int_sync1, int_sync2;
    logic [5:0]            hw_ip;
    logic [7:0]            ip;
    logic [31:0]           count, compare;
    logic                  ti;

    logic        active, exc_any, int_req;
    logic        exc_take, eret_take, mtc0_take;
    logic [4:0]  exc_code;
    logic        set_badvaddr;
    logic [31:0] bad_addr;

`ifdef CP0_TIMER_EN
    logic count_we, compare_we;
    assign count_we   = mtc0_take && (cp0_addr == CP0_ADDR_COUNT);
    assign compare_we = mtc0_take && (cp0_addr == CP0_ADDR_COMPARE);

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .count_we   (count_we),
        .compare_we (compare_we),
        .wdata      (cp0_wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );
`else
    assign count   = '0;
    assign compare = '0;
    assign ti      = 1'b0;
`endif

    // Two-flop synchroniser for the asynchronous interrupt lines
    always_ff @(posedge clk) begin
        if (!resetn) begin
            int_sync1 <= '0;
            int_sync2 <= '0;
        end else begin
            int_sync1 <= hw_int;
            int_sync2 <= int_sync1;
        end
    end

    // Assemble Cause from stored fields and live interrupt levels; line 5 shares IP7 with TI
    always_comb begin
        hw_ip                   = '0;
        hw_ip[NUM_HW_INT-1:0]   = int_sync2;
        ip                      = {ti | hw_ip[5], hw_ip[4:0], cause_sw};
        cause                   = {cause_bd, 15'b0, ip, 1'b0, cause_exc, 2'b0};
        int_req                 = (|(status[15:8] & ip)) & status[ST_IE] & ~status[ST_EXL];
    end

    // Prioritise interrupt, exceptions, eret and mtc0; drive redirect and next state
    always_comb begin
        active       = resetn & wb_valid & (state == S_IDLE);
        exc_any      = int_req | (|wb_exc);
        exc_code     = EXC_INT;
        set_badvaddr = 1'b0;
        bad_addr     = wb_dm_addr;
        if (int_req) begin
            exc_code = EXC_INT;
        end else if (wb_exc[WB_EXC_FETCH]) begin
            exc_code     = EXC_ADEL;
            set_badvaddr = 1'b1;
            bad_addr     = wb_pc;
        end else if (wb_exc[WB_EXC_RSVD]) begin
            exc_code = EXC_RI;
        end else if (wb_exc[WB_EXC_OVF]) begin
            exc_code = EXC_OV;
        end else if (wb_exc[WB_EXC_SYSCALL]) begin
            exc_code = EXC_SYS;
        end else if (wb_exc[WB_EXC_BRK]) begin
            exc_code = EXC_BP;
        end else if (wb_exc[WB_EXC_RADDR]) begin
            exc_code     = EXC_ADEL;
            set_badvaddr = 1'b1;
        end else if (wb_exc[WB_EXC_WADDR]) begin
            exc_code     = EXC_ADES;
            set_badvaddr = 1'b1;
        end

        exc_take  = active & exc_any;
        eret_take = active & ~exc_any & wb_eret;
        mtc0_take = active & ~exc_any & ~wb_eret & wb_mtc0;

        exc_valid = exc_take | eret_take;
        cancel    = exc_valid;
        exc_pc    = eret_take ? epc : EXC_VECTOR;
        wb_commit = active & ~exc_any;

        state_next = state;
        case (state)
            S_IDLE:  if (exc_valid) state_next = S_FLUSH;
            S_FLUSH: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Status/Cause/EPC/BadVAddr updates: exception beats eret beats mtc0
    always_ff @(posedge clk) begin
        if (!resetn) begin
            status    <= STATUS_RESET;
            epc       <= '0;
            badvaddr  <= '0;
            cause_bd  <= 1'b0;
            cause_exc <= '0;
            cause_sw  <= '0;
        end else if (exc_take) begin
            cause_exc      <= exc_code;
            status[ST_EXL] <= 1'b1;
            if (!status[ST_EXL]) begin
                epc      <= wb_delay_slot ? (wb_pc - 32'd4) : wb_pc;
                cause_bd <= wb_delay_slot;
            end
            if (set_badvaddr) begin
                badvaddr <= bad_addr;
            end
        end else if (eret_take) begin
            status[ST_EXL] <= 1'b0;
        end else if (mtc0_take) begin
            case (cp0_addr)
                CP0_ADDR_STATUS: status   <= (status & ~STATUS_WMASK) | (cp0_wdata & STATUS_WMASK);
                CP0_ADDR_CAUSE:  cause_sw <= cp0_wdata[CA_SW_LO +: 2];
                CP0_ADDR_EPC:    epc      <= cp0_wdata;
                default: ;
            endcase
        end
    end

    // mfc0 read mux; unimplemented addresses read zero
    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            CP0_ADDR_BADVADDR: cp0_rdata = badvaddr;
            CP0_ADDR_COUNT:    cp0_rdata = count;
            CP0_ADDR_COMPARE:  cp0_rdata = compare;
            CP0_ADDR_STATUS:   cp0_rdata = status;
            CP0_ADDR_CAUSE:    cp0_rdata = cause;
            CP0_ADDR_EPC:      cp0_rdata = epc;
            default: ;
        endcase
    end

    assign status_o = status;
    assign cause_o  = cause;
    assign epc_o    = epc;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb/tb_cp0_exc_unit.sv - randomized self-checking bench for cp0_exc_unit against a behavioural model
module tb_cp0_exc_unit;

    localparam int          NUM_HW_INT = 6;
    localparam int          COUNT_DIV  = 2;
    localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;
`ifdef CP0_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    localparam logic [7:0] A_BADV    = 8'h40;
    localparam logic [7:0] A_COUNT   = 8'h48;
    localparam logic [7:0] A_COMPARE = 8'h58;
    localparam logic [7:0] A_STATUS  = 8'h60;
    localparam logic [7:0] A_CAUSE   = 8'h68;
    localparam logic [7:0] A_EPC     = 8'h70;

    // Exception priority order: wb_exc bit, ExcCode, BadVAddr source (0 none, 1 pc, 2 data addr)
    localparam int PRIO_BIT  [7] = '{6, 5, 4, 3, 2, 1, 0};
    localparam int PRIO_CODE [7] = '{4, 10, 12, 8, 9, 4, 5};
    localparam int PRIO_BAD  [7] = '{1, 0, 0, 0, 0, 2, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  resetn;
    logic                  wb_valid;
    logic [31:0]           wb_pc;
    logic                  wb_delay_slot;
    logic [6:0]            wb_exc;
    logic [31:0]           wb_dm_addr;
    logic                  wb_eret;
    logic                  wb_mtc0;
    logic [7:0]            cp0_addr;
    logic [31:0]           cp0_wdata;
    logic [31:0]           cp0_rdata;
    logic [NUM_HW_INT-1:0] hw_int;
    logic                  wb_commit;
    logic                  exc_valid;
    logic [31:0]           exc_pc;
    logic                  cancel;
    logic [31:0]           status_o, cause_o, epc_o;

    cp0_exc_unit #(
        .NUM_HW_INT (NUM_HW_INT),
        .COUNT_DIV  (COUNT_DIV),
        .EXC_VECTOR (EXC_VECTOR)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .wb_valid      (wb_valid),
        .wb_pc         (wb_pc),
        .wb_delay_slot (wb_delay_slot),
        .wb_exc        (wb_exc),
        .wb_dm_addr    (wb_dm_addr),
        .wb_eret       (wb_eret),
        .wb_mtc0       (wb_mtc0),
        .cp0_addr      (cp0_addr),
        .cp0_wdata     (cp0_wdata),
        .cp0_rdata     (cp0_rdata),
        .hw_int        (hw_int),
        .wb_commit     (wb_commit),
        .exc_valid     (exc_valid),
        .exc_pc        (exc_pc),
        .cancel        (cancel),
        .status_o      (status_o),
        .cause_o       (cause_o),
        .epc_o         (epc_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd, m_ti, m_flush;
    logic [1:0]  m_sw;
    logic [4:0]  m_code;
    logic [31:0] m_epc, m_bad, m_count, m_compare;
    int          m_cycles;
    logic [5:0]  hw_hist[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_ip();
        logic [5:0] h;
        h = hw_hist[0];
        return {m_ti | h[5], h[4:0], m_sw};
    endfunction

    function automatic logic [31:0] m_status();
        return 32'h0040_0000 | {16'b0, m_im, 6'b0, m_exl, m_ie};
    endfunction

    function automatic logic [31:0] m_cause();
        return {m_bd, 15'b0, m_ip(), 1'b0, m_code, 2'b0};
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (a)
            A_BADV:    return m_bad;
            A_COUNT:   return m_count;
            A_COMPARE: return m_compare;
            A_STATUS:  return m_status();
            A_CAUSE:   return m_cause();
            A_EPC:     return m_epc;
            default:   return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_im = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_flush = 0;
        m_sw = '0; m_code = '0; m_epc = '0; m_bad = '0; m_count = '0; m_compare = '0;
        m_cycles = 0;
        hw_hist.delete();
        hw_hist.push_back('0);
        hw_hist.push_back('0);
    endtask

    task automatic set_idle();
        wb_valid = 0; wb_pc = '0; wb_delay_slot = 0; wb_exc = '0; wb_dm_addr = '0;
        wb_eret = 0; wb_mtc0 = 0; cp0_addr = A_STATUS; cp0_wdata = '0;
    endtask

    // Compare the DUT to the model for the current inputs, then advance the model across the edge
    task automatic step();
        logic [7:0] ip;
        logic       ireq, act, any_exc, take, eret_t, mtc0_t, tick, wr_cnt, wr_cmp, match;
        logic [4:0] code;
        int         sel;
        #1;
        ip      = m_ip();
        ireq    = (|(m_im & ip)) & m_ie & ~m_exl;
        act     = wb_valid & ~m_flush;
        any_exc = ireq | (|wb_exc);
        take    = act & any_exc;
        eret_t  = act & ~any_exc & wb_eret;
        mtc0_t  = act & ~any_exc & ~wb_eret & wb_mtc0;
        sel = -1;
        if (!ireq) begin
            for (int i = 0; i < 7; i++) begin
                if (sel < 0 && wb_exc[PRIO_BIT[i]]) sel = i;
            end
        end
        code = (sel < 0) ? 5'd0 : 5'(PRIO_CODE[sel]);

        check("exc_valid", exc_valid, take | eret_t);
        check("cancel", cancel, take | eret_t);
        check("wb_commit", wb_commit, act & ~any_exc);
        if (take | eret_t) check("exc_pc", exc_pc, eret_t ? m_epc : EXC_VECTOR);
        check("cp0_rdata", cp0_rdata, m_read(cp0_addr));
        check("status_o", status_o, m_status());
        check("cause_o", cause_o, m_cause());
        check("epc_o", epc_o, m_epc);

        tick   = TIMER && ((m_cycles % COUNT_DIV) == COUNT_DIV - 1);
        wr_cnt = TIMER && mtc0_t && (cp0_addr == A_COUNT);
        wr_cmp = TIMER && mtc0_t && (cp0_addr == A_COMPARE);
        match  = tick && !wr_cnt && ((m_count + 32'd1) == m_compare);
        if (wr_cnt) m_count = cp0_wdata;
        else if (tick) m_count = m_count + 32'd1;
        if (wr_cmp) begin
            m_compare = cp0_wdata;
            m_ti = 0;
        end else if (match) begin
            m_ti = 1;
        end

        if (take) begin
            m_code = code;
            if (!m_exl) begin
                m_epc = wb_delay_slot ? wb_pc - 32'd4 : wb_pc;
                m_bd  = wb_delay_slot;
            end
            m_exl = 1;
            if (sel >= 0 && PRIO_BAD[sel] == 1) m_bad = wb_pc;
            if (sel >= 0 && PRIO_BAD[sel] == 2) m_bad = wb_dm_addr;
        end else if (eret_t) begin
            m_exl = 0;
        end else if (mtc0_t) begin
            case (cp0_addr)
                A_STATUS: begin m_im = cp0_wdata[15:8]; m_exl = cp0_wdata[1]; m_ie = cp0_wdata[0]; end
                A_CAUSE:  m_sw = cp0_wdata[9:8];
                A_EPC:    m_epc = cp0_wdata;
                default: ;
            endcase
        end
        m_flush = take | eret_t;
        m_cycles++;
        hw_hist.push_back(hw_int);
        void'(hw_hist.pop_front());
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 0;
        set_idle();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_status", status_o, 32'h0040_0000);
        check("rst_cause", cause_o, 32'h0);
        check("rst_epc", epc_o, 32'h0);
        check("rst_exc_valid", exc_valid, 1'b0);
        check("rst_cancel", cancel, 1'b0);
        check("rst_commit", wb_commit, 1'b0);
        model_reset();
        resetn = 1;
    endtask

    task automatic rand_inputs();
        logic [7:0] addr_tab [8];
        int         b;
        addr_tab = '{A_BADV, A_COUNT, A_COMPARE, A_STATUS, A_CAUSE, A_EPC, 8'h00, 8'h61};
        wb_valid      = ($urandom_range(0, 9) < 7);
        wb_pc         = $urandom & 32'hFFFF_FFFC;
        wb_delay_slot = 1'($urandom_range(0, 1));
        wb_exc        = ($urandom_range(0, 4) == 0) ? 7'($urandom) : 7'd0;
        wb_dm_addr    = $urandom;
        wb_eret       = ($urandom_range(0, 9) == 0);
        wb_mtc0       = ($urandom_range(0, 2) == 0);
        cp0_addr      = addr_tab[$urandom_range(0, 7)];
        cp0_wdata     = $urandom;
        if (cp0_addr == A_STATUS) begin
            cp0_wdata[0] = ($urandom_range(0, 3) != 0);
            cp0_wdata[1] = ($urandom_range(0, 3) == 0);
        end
        if (cp0_addr == A_COMPARE) cp0_wdata = m_count + 32'($urandom_range(1, 12));
        if (cp0_addr == A_COUNT)   cp0_wdata = m_compare - 32'($urandom_range(1, 12));
        if ($urandom_range(0, 7) == 0) begin
            b = $urandom_range(0, NUM_HW_INT - 1);
            hw_int[b] = ~hw_int[b];
        end
    endtask

    initial begin
        resetn = 0;
        hw_int = '0;
        set_idle();
        do_reset();

        // Syscall outside a delay slot, then the flush cycle
        wb_valid = 1; wb_pc = 32'hBFC00100; wb_exc = 7'b0001000;
        #1;
        check("sys_exc_pc", exc_pc, 32'hBFC00380);
        check("sys_commit", wb_commit, 1'b0);
        step();
        set_idle(); wb_valid = 1;
        #1;
        check("sys_epc", epc_o, 32'hBFC00100);
        check("sys_code", 32'(cause_o[6:2]), 32'd8);
        check("sys_exl", 32'(status_o[1]), 32'd1);
        check("flush_exc_valid", exc_valid, 1'b0);
        step();

        // Overflow beats waddr_err in a delay slot
        do_reset();
        wb_valid = 1; wb_pc = 32'h8000_0010; wb_delay_slot = 1; wb_exc = 7'b0010001; wb_dm_addr = 32'hDEAD_0000;
        step();
        set_idle(); cp0_addr = A_BADV;
        #1;
        check("ov_code", 32'(cause_o[6:2]), 32'd12);
        check("ov_epc", epc_o, 32'h8000_000C);
        check("ov_bd", 32'(cause_o[31]), 32'd1);
        check("ov_badvaddr", cp0_rdata, 32'h0);
        step();

        // Second exception with EXL already set keeps EPC
        set_idle(); wb_valid = 1; wb_pc = 32'h8000_0100; wb_exc = 7'b0000100;
        step();
        set_idle();
        #1;
        check("nest_epc", epc_o, 32'h8000_000C);
        check("nest_code", 32'(cause_o[6:2]), 32'd9);
        step();

        // eret with a simultaneous mtc0 EPC
        set_idle(); wb_valid = 1; wb_mtc0 = 1; cp0_addr = A_EPC; cp0_wdata = 32'h8000_1000;
        step();
        set_idle(); wb_valid = 1; wb_eret = 1; wb_mtc0 = 1; cp0_addr = A_EPC; cp0_wdata = 32'h1234_5678;
        #1;
        check("eret_pc", exc_pc, 32'h8000_1000);
        step();
        set_idle();
        #1;
        check("eret_exl", 32'(status_o[1]), 32'd0);
        check("eret_epc", epc_o, 32'h8000_1000);
        step();

        // Reset during FLUSH returns to IDLE
        set_idle(); wb_valid = 1; wb_exc = 7'b0001000;
        step();
        do_reset();
        wb_valid = 1;
        #1;
        check("rst_flush_commit", wb_commit, 1'b1);
        step();

        // hw_int[0] pulse: masked, then unmasked
        set_idle(); wb_valid = 1; wb_mtc0 = 1; cp0_addr = A_STATUS; cp0_wdata = 32'h0000_0001;
        step();
        set_idle(); wb_valid = 1; cp0_addr = A_CAUSE; hw_int = 6'b000001;
        step();
        step();
        #1;
        check("ip2_visible", 32'(cause_o[10]), 32'd1);
        check("ip2_masked", exc_valid, 1'b0);
        step();
        hw_int = '0;
        step(); step(); step();
        set_idle(); wb_valid = 1; wb_mtc0 = 1; cp0_addr = A_STATUS; cp0_wdata = 32'h0000_0401;
        step();
        set_idle(); hw_int = 6'b000001;
        step(); step();
        wb_valid = 1;
        #1;
        check("ip2_int_taken", exc_valid, 1'b1);
        step();
        set_idle(); hw_int = '0;
        #1;
        check("ip2_code", 32'(cause_o[6:2]), 32'd0);
        step();

`ifdef CP0_TIMER_EN
        // Timer: Compare=5 with COUNT_DIV=2 raises TI after ten cycles
        do_reset();
        wb_valid = 1; wb_mtc0 = 1; cp0_addr = A_COMPARE; cp0_wdata = 32'd5;
        step();
        set_idle(); wb_valid = 1; wb_mtc0 = 1; cp0_addr = A_STATUS; cp0_wdata = 32'h0000_8001;
        step();
        set_idle();
        repeat (8) step();
        wb_valid = 1;
        #1;
        check("ti_set", 32'(cause_o[15]), 32'd1);
        check("ti_int", exc_valid, 1'b1);
        step();
        set_idle();
        step();
        wb_valid = 1; wb_mtc0 = 1; cp0_addr = A_COMPARE; cp0_wdata = 32'd100;
        step();
        set_idle();
        #1;
        check("ti_clear", 32'(cause_o[15]), 32'd0);
        step();
`endif

        // Randomized phase
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            rand_inputs();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
